// File: rtl/obi_fifo_arb_pkg.sv
// Shared types and helpers for the OBI FIFO write arbiter: state encoding,
// index-width helper and the round-robin pick function.
package obi_fifo_arb_pkg;

    // Upper bound on NUM_MASTERS supported by rr_pick.
    localparam int unsigned MaxMasters = 32;
    localparam int unsigned MaxIdxW    = 5;

    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic               valid;
        logic [MaxIdxW-1:0] idx;
    } rr_pick_t;

    function automatic int unsigned idx_width(input int unsigned n);
        if (n <= 2) return 1;
        return $clog2(n);
    endfunction

    // First asserted request at or above ptr, wrapping modulo num.
    function automatic rr_pick_t rr_pick(input logic [MaxMasters-1:0] req,
                                         input int unsigned            num,
                                         input int unsigned            ptr);
        rr_pick_t    pick;
        int unsigned k;
        pick = '0;
        for (int unsigned i = 0; i < MaxMasters; i++) begin
            if (i < num && !pick.valid) begin
                k = ptr + i;
                if (k >= num) k = k - num;
                if (req[k[MaxIdxW-1:0]]) begin
                    pick.valid = 1'b1;
                    pick.idx   = k[MaxIdxW-1:0];
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/fifo_v3.sv
// Small synchronous FIFO with combinational head output; used as the
// in-order ID queue of outstanding transactions.
module fifo_v3 #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic                  testmode_i,
    output logic                  full_o,
    output logic                  empty_o,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  push_i,
    output logic [DATA_WIDTH-1:0] data_o,
    input  logic                  pop_i
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]       cnt_q;
    logic                  do_push, do_pop;
    logic                  unused_testmode;

    assign unused_testmode = testmode_i;

    assign full_o  = (cnt_q == CntW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign data_o  = mem_q[rd_ptr_q];

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        if (p == PtrW'(DEPTH - 1)) return '0;
        return p + PtrW'(1);
    endfunction

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            // Simultaneous push and pop leaves the count unchanged.
            if (do_push && !do_pop)      cnt_q <= cnt_q + CntW'(1);
            else if (!do_push && do_pop) cnt_q <= cnt_q - CntW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/obi_fifo_write_arbiter.sv
// Round-robin arbiter sharing one OBI writer port among NUM_MASTERS requesters,
// holding the slave request stable until granted and routing responses in order.
module obi_fifo_write_arbiter
    import obi_fifo_arb_pkg::*;
#(
    parameter int unsigned NUM_MASTERS     = 2,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic [NUM_MASTERS-1:0]            m_req_i,
    output logic [NUM_MASTERS-1:0]            m_gnt_o,
    output logic [NUM_MASTERS-1:0]            m_rvalid_o,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr_i,
    input  logic [NUM_MASTERS-1:0]            m_we_i,
    input  logic [NUM_MASTERS*4-1:0]          m_be_i,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_wdata_i,
    output logic [NUM_MASTERS*DATA_WIDTH-1:0] m_rdata_o,
    output logic                              s_req_o,
    input  logic                              s_gnt_i,
    input  logic                              s_rvalid_i,
    output logic [ADDR_WIDTH-1:0]             s_addr_o,
    output logic                              s_we_o,
    output logic [3:0]                        s_be_o,
    output logic [DATA_WIDTH-1:0]             s_wdata_o,
    input  logic [DATA_WIDTH-1:0]             s_rdata_i,
    output logic                              err_o
);

    localparam int unsigned IdxW = idx_width(NUM_MASTERS);

    arb_state_e              state_q, state_d;
    logic [IdxW-1:0]         ptr_q, lock_idx_q;
    logic                    err_q;
    logic [MaxMasters-1:0]   req_ext;
    rr_pick_t                pick;
    logic                    win_valid;
    logic [IdxW-1:0]         win_idx;
    logic                    hs;
    logic                    q_full, q_empty, q_pop;
    logic [IdxW-1:0]         q_head;

    always_comb begin
        req_ext                  = '0;
        req_ext[NUM_MASTERS-1:0] = m_req_i;
        pick                     = rr_pick(req_ext, NUM_MASTERS, 32'(ptr_q));
    end

    // Winner selection and next-state logic.
    always_comb begin
        state_d   = state_q;
        win_valid = pick.valid;
        win_idx   = pick.idx[IdxW-1:0];
        s_req_o   = 1'b0;
        case (state_q)
            ARB: begin
                s_req_o = rst_ni & pick.valid & ~q_full;
                if (s_req_o && !s_gnt_i) state_d = LOCKED;
            end
            LOCKED: begin
                win_valid = 1'b1;
                win_idx   = lock_idx_q;
                s_req_o   = rst_ni;
                if (s_gnt_i) state_d = ARB;
            end
            default: state_d = ARB;
        endcase
    end

    assign hs = s_req_o & s_gnt_i;

    always_comb begin
        s_addr_o  = '0;
        s_we_o    = 1'b0;
        s_be_o    = '0;
        s_wdata_o = '0;
        m_gnt_o   = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (win_valid && win_idx == IdxW'(i)) begin
                s_addr_o   = m_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
                s_we_o     = m_we_i[i];
                s_be_o     = m_be_i[i*4 +: 4];
                s_wdata_o  = m_wdata_i[i*DATA_WIDTH +: DATA_WIDTH];
                m_gnt_o[i] = hs;
            end
        end
    end

    // Responses go to the oldest outstanding issuer; rdata is broadcast.
    assign q_pop = rst_ni & s_rvalid_i & ~q_empty;

    always_comb begin
        m_rvalid_o = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            m_rvalid_o[i] = q_pop & (q_head == IdxW'(i));
        end
    end

    assign m_rdata_o = {NUM_MASTERS{s_rdata_i}};
    assign err_o     = err_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ARB;
            ptr_q      <= '0;
            lock_idx_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == ARB && s_req_o && !s_gnt_i) lock_idx_q <= win_idx;
            if (hs) begin
                ptr_q <= (win_idx == IdxW'(NUM_MASTERS - 1)) ? '0 : win_idx + IdxW'(1);
            end
            if (s_rvalid_i && q_empty) err_q <= 1'b1;
        end
    end

    fifo_v3 #(
        .DATA_WIDTH (IdxW),
        .DEPTH      (MAX_OUTSTANDING)
    ) i_id_queue (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .flush_i    (1'b0),
        .testmode_i (1'b0),
        .full_o     (q_full),
        .empty_o    (q_empty),
        .data_i     (win_idx),
        .push_i     (hs),
        .data_o     (q_head),
        .pop_i      (q_pop)
    );

endmodule

// File: tb/tb_obi_fifo_write_arbiter.sv
// Directed bench for obi_fifo_write_arbiter with a queue-level reference model
// checked every cycle plus literal per-scenario expectations.
module tb_obi_fifo_write_arbiter;

    localparam int N    = 2;
    localparam int MAXO = 2;

    logic        clk, rst_ni;
    logic [1:0]  m_req, m_gnt, m_rvalid, m_we;
    logic [63:0] m_addr, m_wdata, m_rdata;
    logic [7:0]  m_be;
    logic        s_req, s_gnt, s_rvalid, s_we, err;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic [3:0]  s_be;

    logic [31:0] addr_tab  [N] = '{32'h0000_1000, 32'h0000_2000};
    logic [31:0] wdata_tab [N] = '{32'h0000_00A0, 32'h0000_00B1};
    logic [3:0]  be_tab    [N] = '{4'hF, 4'h3};
    logic        we_tab    [N] = '{1'b1, 1'b0};

    int total = 0;
    int bad   = 0;

    // Reference model state
    int          mdl_ptr    = 0;
    bit          mdl_locked = 0;
    int          mdl_lidx   = 0;
    bit          mdl_err    = 0;
    logic [31:0] exp_q[$];

    obi_fifo_write_arbiter #(
        .NUM_MASTERS(N), .DATA_WIDTH(32), .ADDR_WIDTH(32), .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .m_req_i(m_req), .m_gnt_o(m_gnt), .m_rvalid_o(m_rvalid),
        .m_addr_i(m_addr), .m_we_i(m_we), .m_be_i(m_be), .m_wdata_i(m_wdata),
        .m_rdata_o(m_rdata),
        .s_req_o(s_req), .s_gnt_i(s_gnt), .s_rvalid_i(s_rvalid),
        .s_addr_o(s_addr), .s_we_o(s_we), .s_be_o(s_be), .s_wdata_o(s_wdata),
        .s_rdata_i(s_rdata), .err_o(err)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [1:0] req, input logic gnt, input logic rv,
                         input logic [31:0] rd);
        @(posedge clk);
        #1;
        m_req    = req;
        s_gnt    = gnt;
        s_rvalid = rv;
        s_rdata  = rd;
        #1;
    endtask

    // Per-cycle compare against the model, then advance the model.
    always @(negedge clk) begin : cmp
        bit          wv, e_sreq, pop_ok;
        int          w, c;
        logic [1:0]  e_gnt, e_rv;
        if (!rst_ni) begin
            mdl_ptr = 0; mdl_locked = 0; mdl_lidx = 0; mdl_err = 0;
            exp_q.delete();
            chk("rst_s_req", 32'(s_req), 32'h0);
            chk("rst_m_gnt", 32'(m_gnt), 32'h0);
            chk("rst_m_rvalid", 32'(m_rvalid), 32'h0);
            chk("rst_err", 32'(err), 32'h0);
        end else begin
            wv = 0; w = 0;
            if (mdl_locked) begin
                wv = 1; w = mdl_lidx;
            end else begin
                for (int k = 0; k < N; k++) begin
                    c = (mdl_ptr + k) % N;
                    if (!wv && m_req[c]) begin wv = 1; w = c; end
                end
            end
            e_sreq = mdl_locked || (wv && exp_q.size() < MAXO);
            e_gnt  = (e_sreq && s_gnt) ? 2'(1 << w) : 2'b00;
            e_rv   = (s_rvalid && exp_q.size() > 0) ? 2'(1 << exp_q[0]) : 2'b00;
            chk("mdl_s_req", 32'(s_req), 32'(e_sreq));
            chk("mdl_m_gnt", 32'(m_gnt), 32'(e_gnt));
            chk("mdl_m_rvalid", 32'(m_rvalid), 32'(e_rv));
            chk("mdl_err", 32'(err), 32'(mdl_err));
            chk("mdl_s_addr", s_addr, wv ? addr_tab[w] : 32'h0);
            chk("mdl_s_wdata", s_wdata, wv ? wdata_tab[w] : 32'h0);
            chk("mdl_s_be", 32'(s_be), wv ? 32'(be_tab[w]) : 32'h0);
            chk("mdl_s_we", 32'(s_we), wv ? 32'(we_tab[w]) : 32'h0);
            if (e_rv != 2'b00) begin
                for (int l = 0; l < N; l++) chk("mdl_m_rdata", m_rdata[l*32 +: 32], s_rdata);
            end
            pop_ok = s_rvalid && exp_q.size() > 0;
            if (s_rvalid && !pop_ok) mdl_err = 1;
            if (pop_ok) void'(exp_q.pop_front());
            if (e_sreq && s_gnt) begin
                mdl_ptr    = (w + 1) % N;
                mdl_locked = 0;
                exp_q.push_back(32'(w));
            end else if (e_sreq) begin
                mdl_locked = 1;
                mdl_lidx   = w;
            end
        end
    end

    initial begin
        rst_ni   = 1'b0;
        m_req    = '0;
        s_gnt    = 1'b0;
        s_rvalid = 1'b0;
        s_rdata  = '0;
        m_addr   = {addr_tab[1], addr_tab[0]};
        m_wdata  = {wdata_tab[1], wdata_tab[0]};
        m_be     = {be_tab[1], be_tab[0]};
        m_we     = {we_tab[1], we_tab[0]};

        // outputs stay low in reset even with requests and grant present
        drive(2'b11, 1'b1, 1'b0, 32'h0);
        chk("t1_rst_s_req", 32'(s_req), 32'h0);
        chk("t1_rst_m_gnt", 32'(m_gnt), 32'h0);
        @(posedge clk); #1;
        rst_ni = 1'b1; m_req = 2'b00; s_gnt = 1'b0; #1;
        chk("t1_idle_s_req", 32'(s_req), 32'h0);
        chk("t1_idle_m_gnt", 32'(m_gnt), 32'h0);
        chk("t1_idle_err", 32'(err), 32'h0);

        // both masters requesting, grant every cycle: strict alternation
        drive(2'b11, 1'b1, 1'b0, 32'h0);
        chk("t2_gnt_c1", 32'(m_gnt), 32'h1);
        chk("t2_wdata_c1", s_wdata, 32'hA0);
        drive(2'b11, 1'b1, 1'b1, 32'h11);
        chk("t2_gnt_c2", 32'(m_gnt), 32'h2);
        chk("t2_wdata_c2", s_wdata, 32'hB1);
        chk("t2_rvalid_c2", 32'(m_rvalid), 32'h1);
        chk("t2_rdata_c2", m_rdata[31:0], 32'h11);
        drive(2'b11, 1'b1, 1'b1, 32'h22);
        chk("t2_gnt_c3", 32'(m_gnt), 32'h1);
        chk("t2_rvalid_c3", 32'(m_rvalid), 32'h2);
        drive(2'b11, 1'b1, 1'b1, 32'h33);
        chk("t2_gnt_c4", 32'(m_gnt), 32'h2);
        chk("t2_rvalid_c4", 32'(m_rvalid), 32'h1);
        drive(2'b00, 1'b0, 1'b1, 32'h44);
        chk("t2_rvalid_c5", 32'(m_rvalid), 32'h2);
        chk("t2_s_req_c5", 32'(s_req), 32'h0);

        // stalled m0 request stays locked while m1 joins
        drive(2'b01, 1'b0, 1'b0, 32'h0);
        chk("t3_s_req_c1", 32'(s_req), 32'h1);
        chk("t3_addr_c1", s_addr, 32'h1000);
        chk("t3_gnt_c1", 32'(m_gnt), 32'h0);
        drive(2'b11, 1'b0, 1'b0, 32'h0);
        chk("t3_addr_c2", s_addr, 32'h1000);
        chk("t3_wdata_c2", s_wdata, 32'hA0);
        drive(2'b11, 1'b0, 1'b0, 32'h0);
        chk("t3_addr_c3", s_addr, 32'h1000);
        chk("t3_s_req_c3", 32'(s_req), 32'h1);
        drive(2'b11, 1'b1, 1'b0, 32'h0);
        chk("t3_gnt_c4", 32'(m_gnt), 32'h1);
        drive(2'b11, 1'b1, 1'b0, 32'h0);
        chk("t3_gnt_c5", 32'(m_gnt), 32'h2);
        chk("t3_wdata_c5", s_wdata, 32'hB1);
        drive(2'b00, 1'b0, 1'b1, 32'h55);
        chk("t3_rvalid_c6", 32'(m_rvalid), 32'h1);
        drive(2'b00, 1'b0, 1'b1, 32'h66);
        chk("t3_rvalid_c7", 32'(m_rvalid), 32'h2);

        // m1 then m0 granted, queue full blocks the next request
        drive(2'b10, 1'b1, 1'b0, 32'h0);
        chk("t4_gnt_c1", 32'(m_gnt), 32'h2);
        drive(2'b01, 1'b1, 1'b0, 32'h0);
        chk("t4_gnt_c2", 32'(m_gnt), 32'h1);
        drive(2'b01, 1'b1, 1'b0, 32'h0);
        chk("t4_full_s_req", 32'(s_req), 32'h0);
        chk("t4_full_gnt", 32'(m_gnt), 32'h0);
        drive(2'b01, 1'b1, 1'b1, 32'h11);
        chk("t4_s_req_pop", 32'(s_req), 32'h0);
        chk("t4_rvalid_1", 32'(m_rvalid), 32'h2);
        chk("t4_rdata_1", m_rdata[63:32], 32'h11);
        drive(2'b01, 1'b0, 1'b1, 32'h22);
        chk("t4_s_req_after", 32'(s_req), 32'h1);
        chk("t4_rvalid_0", 32'(m_rvalid), 32'h1);
        chk("t4_rdata_0", m_rdata[31:0], 32'h22);
        drive(2'b01, 1'b1, 1'b0, 32'h0);
        chk("t4_gnt_c6", 32'(m_gnt), 32'h1);
        drive(2'b00, 1'b0, 1'b1, 32'h33);
        chk("t4_rvalid_c7", 32'(m_rvalid), 32'h1);

        // mixed traffic checked by the model alone
        for (int i = 0; i < 60; i++) begin
            drive(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  (exp_q.size() > 0) ? 1'($urandom_range(0, 1)) : 1'b0,
                  32'($urandom_range(0, 32'hFFFF)));
        end

        // reset with transactions outstanding drops them
        drive(2'b11, 1'b1, 1'b0, 32'h0);
        @(posedge clk); #1;
        rst_ni = 1'b0; #1;
        chk("t5_rst_s_req", 32'(s_req), 32'h0);
        chk("t5_rst_gnt", 32'(m_gnt), 32'h0);
        chk("t5_rst_err", 32'(err), 32'h0);
        @(posedge clk); #1;
        rst_ni = 1'b1; m_req = 2'b00; s_gnt = 1'b0; s_rvalid = 1'b0;
        drive(2'b00, 1'b0, 1'b1, 32'h77);
        chk("t5_stray_rvalid", 32'(m_rvalid), 32'h0);
        chk("t5_err_same_cycle", 32'(err), 32'h0);
        drive(2'b00, 1'b0, 1'b0, 32'h0);
        chk("t5_err_set", 32'(err), 32'h1);
        drive(2'b11, 1'b1, 1'b0, 32'h0);
        chk("t5_err_sticky", 32'(err), 32'h1);
        chk("t5_ptr_reset_gnt", 32'(m_gnt), 32'h1);
        drive(2'b00, 1'b0, 1'b0, 32'h0);
        drive(2'b00, 1'b0, 1'b0, 32'h0);
        chk("t5_err_sticky2", 32'(err), 32'h1);

        @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
